// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: access-size codes and FSM state encoding for the data-memory responder
package dm_responder_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: little-endian lane merge for stores, lane extract/extend for loads, alignment check
module dm_lane_unit
    import dm_responder_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        is_unsigned,
    output logic [31:0] new_word,
    output logic [31:0] rdata,
    output logic        err
);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] lane;

    // shift the addressed lane to/from bit 0, then mask-merge or extend
    always_comb begin
        sh       = size == SIZE_BYTE ? {lo, 3'b000} : size == SIZE_HALF ? {lo[1], 4'b0000} : 5'd0;
        mask     = (size == SIZE_BYTE ? 32'h0000_00FF : size == SIZE_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
        new_word = (old_word & ~mask) | ((wdata << sh) & mask);
        lane     = old_word >> sh;
        rdata    = size == SIZE_BYTE ? {{24{~is_unsigned & lane[7]}}, lane[7:0]} :
                   size == SIZE_HALF ? {{16{~is_unsigned & lane[15]}}, lane[15:0]} : lane;
        err      = size == SIZE_ILL || (size == SIZE_HALF && lo[0]) || (size == SIZE_WORD && lo != 2'b00);
    end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: wait-state data memory behind a valid/ready load/store port, with store logging
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              log_valid,
    output logic [31:0]       log_pc,
    output logic [31:0]       log_addr,
    output logic [31:0]       log_data
);
    localparam int IW = ADDR_W - 2;

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     clr_idx_q, clr_idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d, uns_q, uns_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, pc_q, pc_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              log_valid_q, log_valid_d;
    logic [31:0]       log_pc_q, log_pc_d, log_addr_q, log_addr_d, log_data_q, log_data_d;

    logic [31:0]       mem [DEPTH];
    logic [IW-1:0]     mem_idx;
    logic              mem_we;
    logic [31:0]       mem_wdata, old_word, new_word, ld_data;
    logic              al_err, accept, commit;

    assign old_word = mem[mem_idx];

    dm_lane_unit u_lane (
        .old_word    (old_word),
        .wdata       (wdata_q),
        .size        (size_q),
        .lo          (addr_q[1:0]),
        .is_unsigned (uns_q),
        .new_word    (new_word),
        .rdata       (ld_data),
        .err         (al_err)
    );

    // next-state: clear sweep, accept/capture, wait countdown, commit, response handshake
    always_comb begin
        accept      = req_valid && state_q == ST_IDLE;
        commit      = state_q == ST_BUSY && cnt_q == 4'd0;
        mem_idx     = state_q == ST_CLEAR ? clr_idx_q : addr_q[ADDR_W-1:2];
        mem_we      = state_q == ST_CLEAR || (commit && we_q && !al_err);
        mem_wdata   = state_q == ST_CLEAR ? 32'd0 : new_word;
        clr_idx_d   = state_q == ST_CLEAR ? clr_idx_q + 1'b1 : clr_idx_q;
        cnt_d       = accept ? 4'(WAIT_CYCLES - 1) : (state_q == ST_BUSY && cnt_q != 4'd0) ? cnt_q - 1'b1 : cnt_q;
        state_d     = (state_q == ST_CLEAR && clr_idx_q == IW'(DEPTH - 1)) ? ST_IDLE :
                      accept ? ST_BUSY :
                      commit ? ST_RESP :
                      (state_q == ST_RESP && resp_ready) ? ST_IDLE : state_q;
        we_d        = accept ? req_we : we_q;
        size_d      = accept ? req_size : size_q;
        uns_d       = accept ? req_unsigned : uns_q;
        addr_d      = accept ? req_addr : addr_q;
        wdata_d     = accept ? req_wdata : wdata_q;
        pc_d        = accept ? req_pc : pc_q;
        rdata_d     = commit ? ((we_q || al_err) ? 32'd0 : ld_data) : rdata_q;
        err_d       = commit ? al_err : err_q;
        log_valid_d = commit && we_q && !al_err;
        log_pc_d    = log_valid_d ? pc_q : log_pc_q;
        log_addr_d  = log_valid_d ? 32'({addr_q[ADDR_W-1:2], 2'b00}) : log_addr_q;
        log_data_d  = log_valid_d ? new_word : log_data_q;
    end

    // control and capture registers; reset drops any in-flight access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            log_valid_q <= 1'b0;
            log_pc_q    <= '0;
            log_addr_q  <= '0;
            log_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            log_valid_q <= log_valid_d;
            log_pc_q    <= log_pc_d;
            log_addr_q  <= log_addr_d;
            log_data_q  <= log_data_d;
        end
    end

    // word array has no reset; the clear sweep defines its contents
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

    assign req_ready  = state_q == ST_IDLE;
    assign resp_valid = state_q == ST_RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign log_valid  = log_valid_q;
    assign log_pc     = log_pc_q;
    assign log_addr   = log_addr_q;
    assign log_data   = log_data_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: table vectors, hand sequences and randomized traffic against a byte-array model
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [5:0]  req_addr = 6'd0;
    logic [31:0] req_wdata = 32'd0, req_pc = 32'd0;

    logic        req_valid = 1'b0, resp_ready = 1'b0, req_ready, resp_valid, resp_err, log_valid;
    logic [31:0] resp_rdata, log_pc, log_addr, log_data;
    logic        req_valid3 = 1'b0, resp_ready3 = 1'b0, req_ready3, resp_valid3, resp_err3, log_valid3;
    logic [31:0] resp_rdata3, log_pc3, log_addr3, log_data3;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] mb [64];

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(6), .DEPTH(16), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .log_valid(log_valid), .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data)
    );

    dm_responder #(.ADDR_W(6), .DEPTH(16), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3),
        .resp_err(resp_err3), .log_valid(log_valid3), .log_pc(log_pc3), .log_addr(log_addr3), .log_data(log_data3)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] rd;
        logic        err;
        logic        logv;
        logic [31:0] ld;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mb[i] = 8'h00;
    endtask

    // byte-granular memory model: an access touches n consecutive bytes
    task automatic model(input logic we, input logic [1:0] size, input logic uns, input logic [5:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                         output logic logv, output logic [31:0] la, output logic [31:0] ld);
        int n;
        int a;
        n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
        a = int'(addr);
        err = size == 2'd3 || (a % n) != 0;
        rd = 32'd0; logv = 1'b0; ld = 32'd0;
        la = {26'd0, addr[5:2], 2'b00};
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mb[a + i] = wdata[8*i +: 8];
                logv = 1'b1;
            end else begin
                for (int i = 0; i < n; i++) rd[8*i +: 8] = mb[a + i];
                if (!uns && rd[8*n-1]) for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hFF;
            end
            ld = {mb[int'(la) + 3], mb[int'(la) + 2], mb[int'(la) + 1], mb[int'(la)]};
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    // one full transaction on the WAIT_CYCLES=2 instance, checked against the model
    task automatic run(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [5:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
                       output logic [31:0] g_rd, output logic g_err, output int g_nlog, output logic [31:0] g_ld);
        logic [31:0] e_rd, e_la, e_ld, g_pc, g_la;
        logic e_err, e_logv;
        int lat;
        model(we, size, uns, addr, wdata, e_rd, e_err, e_logv, e_la, e_ld);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata; req_pc = pc;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; g_nlog = 0; g_pc = 0; g_la = 0; g_ld = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (log_valid) begin g_nlog++; g_pc = log_pc; g_la = log_addr; g_ld = log_data; end
        end while (!resp_valid && lat < 40);
        g_rd = resp_rdata; g_err = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        if (log_valid) g_nlog++;
        chk({tag, " latency"}, 32'(lat), 32'd2);
        chk({tag, " rdata"}, g_rd, e_rd);
        chk({tag, " err"}, 32'(g_err), 32'(e_err));
        chk({tag, " log pulses"}, 32'(g_nlog), 32'(e_logv));
        if (e_logv) begin
            chk({tag, " log_pc"}, g_pc, pc);
            chk({tag, " log_addr"}, g_la, e_la);
            chk({tag, " log_data"}, g_ld, e_ld);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, ld, hold;
        logic err;
        int nlog, lat;

        tbl[0] = '{1'b1, 2'd2, 1'b0, 6'h08, 32'h11223344, 32'h100, 32'h0, 1'b0, 1'b1, 32'h11223344};
        tbl[1] = '{1'b0, 2'd0, 1'b0, 6'h0B, 32'h0, 32'h104, 32'h00000011, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 2'd1, 1'b0, 6'h0A, 32'h0, 32'h108, 32'h00001122, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 2'd2, 1'b0, 6'h08, 32'h0, 32'h10C, 32'h11223344, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 2'd0, 1'b0, 6'h05, 32'h00000080, 32'h200, 32'h0, 1'b0, 1'b1, 32'h00008000};
        tbl[5] = '{1'b0, 2'd0, 1'b0, 6'h05, 32'h0, 32'h204, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 2'd0, 1'b1, 6'h05, 32'h0, 32'h208, 32'h00000080, 1'b0, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 2'd1, 1'b0, 6'h03, 32'h0, 32'h20C, 32'h0, 1'b1, 1'b0, 32'h0};
        tbl[8] = '{1'b1, 2'd2, 1'b0, 6'h06, 32'hCAFEBABE, 32'h210, 32'h0, 1'b1, 1'b0, 32'h0};
        tbl[9] = '{1'b0, 2'd2, 1'b0, 6'h04, 32'h0, 32'h214, 32'h00008000, 1'b0, 1'b0, 32'h0};

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset log_valid", 32'(log_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset log_data", log_data, 32'd0);
        reset = 1'b1;
        model_clear();
        wait_ready("clear cycles");

        for (int i = 0; i < 16; i++) run($sformatf("zero lw %0d", i), 1'b0, 2'd2, 1'b0, 6'(i * 4), 32'd0, 32'h40, rd, err, nlog, ld);

        for (int i = 0; i < 10; i++) begin
            run($sformatf("tbl%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, tbl[i].pc, rd, err, nlog, ld);
            chk($sformatf("tbl%0d rdata const", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d err const", i), 32'(err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d log const", i), 32'(nlog), 32'(tbl[i].logv));
            if (tbl[i].logv) chk($sformatf("tbl%0d log_data const", i), ld, tbl[i].ld);
        end

        // WAIT_CYCLES=3 instance: store, then a load held by backpressure
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 6'h0C; req_wdata = 32'hA5A55A5A; req_pc = 32'h300;
        req_valid3 = 1'b1; resp_ready3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            chk($sformatf("w3 resp_valid edge %0d", e), 32'(resp_valid3), 32'(e == 3));
        end
        @(posedge clk); #1;
        chk("w3 back idle", 32'(req_ready3), 32'd1);
        req_we = 1'b0; req_valid3 = 1'b1; resp_ready3 = 1'b0;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!resp_valid3 && lat < 20);
        chk("w3 load latency", 32'(lat), 32'd3);
        chk("w3 load rdata", resp_rdata3, 32'hA5A55A5A);
        hold = resp_rdata3;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("w3 hold valid", 32'(resp_valid3), 32'd1);
            chk("w3 hold rdata", resp_rdata3, hold);
            chk("w3 hold ready", 32'(req_ready3), 32'd0);
        end
        resp_ready3 = 1'b1;
        @(posedge clk); #1;
        resp_ready3 = 1'b0;
        chk("w3 released valid", 32'(resp_valid3), 32'd0);
        chk("w3 released ready", 32'(req_ready3), 32'd1);

        for (int i = 0; i < 150; i++) begin
            run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 63)), $urandom, $urandom, rd, err, nlog, ld);
        end

        // reset during BUSY on a store: the store must be dropped
        req_we = 1'b1; req_size = 2'd2; req_addr = 6'h10; req_wdata = 32'hDEADBEEF; req_pc = 32'h400;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midreset ready", 32'(req_ready), 32'd0);
        nlog = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (log_valid || resp_valid) nlog++;
        end
        chk("midreset no log/resp", 32'(nlog), 32'd0);
        reset = 1'b1;
        model_clear();
        wait_ready("re-clear cycles");
        run("post-reset lw 0x10", 1'b0, 2'd2, 1'b0, 6'h10, 32'd0, 32'h404, rd, err, nlog, ld);
        chk("post-reset word", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
